pipe_hazard_ctrl: RTL

Central stall/flush scheduler for the 5-stage SRAM-like MIPS pipeline. It generates the per-stage stall and invalidate signals consumed by the IF_ID, ID_EX, EX_MEM and MEM_WB registers. It owns the data-SRAM request handshake FSM and the multiply/divide busy sequencer. It also detects load-use hazards and applies exception/eret flushes.

---
 rtl/pipe_hazard_ctrl.sv | 86 ++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-stage stall/flush scheduler with data-SRAM handshake and mul/div sequencer
module pipe_hazard_ctrl #(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 33,
   parameter int CNT_W      = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_rs_used,
   input  logic       id_rt_used,
   input  logic       ex_load,
   input  logic [4:0] ex_wdst,
   input  logic       ex_md_start,
   input  logic       ex_md_is_div,
   input  logic       mem_access,
   input  logic       data_addr_ok,
   input  logic       data_data_ok,
   input  logic       if_wait,
   input  logic       exc_commit,
   output logic       data_req,
   output logic       IF_stall,
   output logic       ID_stall,
   output logic       EX_stall,
   output logic       MEM_stall,
   output logic       IF_invalid,
   output logic       ID_invalid,
   output logic       EX_invalid,
   output logic       md_busy
);
   typedef enum logic [1:0] {D_IDLE, D_DATA, D_DRAIN} d_t;
   typedef enum logic {M_IDLE, M_BUSY} m_t;
   d_t d_q, d_d;
   m_t m_q, m_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic lu, req, mem_stall, md_stall, ex_s, id_s;
   always_comb begin
      lu = ex_load & (ex_wdst != 5'd0) &
           ((id_rs_used & (id_rs == ex_wdst)) | (id_rt_used & (id_rt == ex_wdst)));
      req = (d_q == D_IDLE) & mem_access & ~exc_commit;
      mem_stall = mem_access & ~((d_q == D_DATA) & data_data_ok) & (d_q != D_DRAIN);
      md_stall = (m_q == M_IDLE) ? ex_md_start : (cnt_q != '0);
      d_d = (d_q == D_IDLE) ? ((req & data_addr_ok) ? D_DATA : D_IDLE) :
            data_data_ok ? D_IDLE :
            ((d_q == D_DATA) & exc_commit) ? D_DRAIN : d_q;
      m_d = m_q;
      cnt_d = cnt_q;
      if (exc_commit) begin
         m_d = M_IDLE;
         cnt_d = '0;
      end else if (m_q == M_IDLE) begin
         if (ex_md_start) begin
            m_d = M_BUSY;
            cnt_d = ex_md_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
         end
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else if (~mem_stall) begin
         m_d = M_IDLE;
      end
      // flush wins over every stall except the fetch-side ones
      ex_s = ~exc_commit & (mem_stall | md_stall);
      id_s = ex_s | (~exc_commit & lu);
      data_req   = ~rst & req;
      MEM_stall  = ~rst & ~exc_commit & mem_stall;
      EX_stall   = ~rst & ex_s;
      ID_stall   = ~rst & id_s;
      IF_stall   = ~rst & (id_s | if_wait | (d_q == D_DRAIN));
      IF_invalid = ~rst & exc_commit;
      ID_invalid = ~rst & exc_commit;
      EX_invalid = ~rst & exc_commit;
      md_busy    = ~rst & (m_q == M_BUSY);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         d_q <= D_IDLE;
         m_q <= M_IDLE;
         cnt_q <= '0;
      end else begin
         d_q <= d_d;
         m_q <= m_d;
         cnt_q <= cnt_d;
      end
   end
endmodule
